// File: rtl/display_capture.sv
// display_capture: receiving end of the multiplexed 4-digit 7-segment bus. Samples and de-glitches
// each digit slot, decodes back to BCD and publishes one frame per scan. Option: DISPLAY_CAPTURE_DOT_EN.
module display_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [7:0] i_Segments,
  input  logic [3:0] i_Digits,
  output logic [3:0] o_Data_Dig1,
  output logic [3:0] o_Data_Dig2,
  output logic [3:0] o_Data_Dig3,
  output logic [3:0] o_Data_Dig4,
  output logic [3:0] o_Blank,
  output logic       o_Dot,
  output logic       o_Frame_Valid,
  output logic       o_Error,
  output logic       o_Timeout
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef DISPLAY_CAPTURE_DOT_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

  typedef struct packed {
    logic       illegal;
    logic       blank;
    logic [3:0] data;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] seg);
    dec_t d;
    d = '{illegal: 1'b0, blank: 1'b0, data: 4'h0};
    case (seg)
      7'h3F: d.data = 4'd0;
      7'h06: d.data = 4'd1;
      7'h5B: d.data = 4'd2;
      7'h4F: d.data = 4'd3;
      7'h66: d.data = 4'd4;
      7'h6D: d.data = 4'd5;
      7'h7D: d.data = 4'd6;
      7'h07: d.data = 4'd7;
      7'h7F: d.data = 4'd8;
      7'h6F: d.data = 4'd9;
      7'h00: d.blank = 1'b1;
      default: begin
        d.data    = 4'hF;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  logic [7:0]      w_seg_norm, r_seg, r_seg_prev;
  logic [3:0]      w_dig_norm, r_dig, r_dig_prev;
  logic [SW-1:0]   r_stable, w_stable_nxt;
  logic [TW-1:0]   r_tcnt;
  logic [3:0]      r_seen;
  logic            r_err;
  logic [3:0][3:0] r_sh_data;
  logic [3:0]      r_sh_blank;
  logic [3:0][3:0] r_out_data;
  logic [3:0]      r_out_blank;
  logic            r_frame_valid, r_out_err, r_out_tmo;
  logic            w_onehot, w_multi, w_same, w_accept;
  logic            w_complete, w_tmo, w_publish;
  logic [1:0]      w_idx;
  dec_t            w_dec;

  assign w_seg_norm = i_Segments ^ {8{SEG_ACTIVE_LOW}};
  assign w_dig_norm = i_Digits ^ {4{DIG_ACTIVE_LOW}};

  assign w_onehot = $onehot(r_dig);
  assign w_multi  = !$onehot0(r_dig);
  assign w_same   = (r_dig == r_dig_prev) && ((r_seg & CMP_MASK) == (r_seg_prev & CMP_MASK));
  assign w_dec    = decode(r_seg[6:0]);

  // Accept exactly once when the run reaches STABLE_CYCLES samples; then hold until the bus changes.
  always_comb begin
    w_stable_nxt = '0;
    w_accept     = 1'b0;
    if (w_onehot && w_same) begin
      if (r_stable == STABLE_LAST) begin
        w_stable_nxt = STABLE_LAST;
      end else begin
        w_stable_nxt = r_stable + 1'b1;
        w_accept     = (w_stable_nxt == STABLE_LAST);
      end
    end
  end

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_dig[k]) w_idx = 2'(k);
    end
  end

  assign w_complete = (r_seen == 4'hF);
  assign w_tmo      = !w_complete && (r_tcnt == TIMEOUT_LAST);
  assign w_publish  = w_complete || w_tmo;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      // NOTE: shadows are reset too so a frame published after reset never carries pre-reset digits.
      r_seg         <= '0;
      r_seg_prev    <= '0;
      r_dig         <= '0;
      r_dig_prev    <= '0;
      r_stable      <= '0;
      r_tcnt        <= '0;
      r_seen        <= '0;
      r_err         <= 1'b0;
      r_sh_data     <= '0;
      r_sh_blank    <= '0;
      r_out_data    <= '0;
      r_out_blank   <= '0;
      r_frame_valid <= 1'b0;
      r_out_err     <= 1'b0;
      r_out_tmo     <= 1'b0;
    end else begin
      r_seg         <= w_seg_norm;
      r_dig         <= w_dig_norm;
      r_seg_prev    <= r_seg;
      r_dig_prev    <= r_dig;
      r_stable      <= w_stable_nxt;
      r_frame_valid <= w_publish;

      if (w_publish) begin
        for (int k = 0; k < 4; k++) begin
          r_out_data[k]  <= r_seen[k] ? r_sh_data[k] : 4'h0;
          r_out_blank[k] <= r_seen[k] ? r_sh_blank[k] : 1'b1;
        end
        r_out_err <= r_err;
        r_out_tmo <= w_tmo;
        r_seen    <= '0;
        r_err     <= 1'b0;
        r_tcnt    <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      // NOTE: these later nonblocking writes override the clears above, so events on a publish cycle land in the next frame.
      if (w_accept) begin
        r_seen[w_idx]     <= 1'b1;
        r_sh_data[w_idx]  <= w_dec.data;
        r_sh_blank[w_idx] <= w_dec.blank;
        if (w_dec.illegal) r_err <= 1'b1;
      end
      if (w_multi) r_err <= 1'b1;
    end
  end

`ifdef DISPLAY_CAPTURE_DOT_EN
  logic r_dot_acc, r_out_dot;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_dot_acc <= 1'b0;
      r_out_dot <= 1'b0;
    end else begin
      if (w_publish) begin
        r_out_dot <= r_dot_acc;
        r_dot_acc <= 1'b0;
      end
      if (w_accept && r_seg[7]) r_dot_acc <= 1'b1;
    end
  end

  assign o_Dot = r_out_dot;
`else
  assign o_Dot = 1'b0;
`endif

  assign o_Data_Dig1   = r_out_data[0];
  assign o_Data_Dig2   = r_out_data[1];
  assign o_Data_Dig3   = r_out_data[2];
  assign o_Data_Dig4   = r_out_data[3];
  assign o_Blank       = r_out_blank;
  assign o_Frame_Valid = r_frame_valid;
  assign o_Error       = r_out_err;
  assign o_Timeout     = r_out_tmo;

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: drives active-low scans into display_capture and compares published frames
// against directed constants and a sample-level run-length reference model.
module tb_display_capture;

  localparam int S   = 4;
  localparam int TMO = 4096;

  localparam logic [6:0] SEG_LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       i_Reset;
  logic [7:0] i_Segments;
  logic [3:0] i_Digits;
  logic [3:0] o_Data_Dig1, o_Data_Dig2, o_Data_Dig3, o_Data_Dig4;
  logic [3:0] o_Blank;
  logic       o_Dot, o_Frame_Valid, o_Error, o_Timeout;

  always #5 clk = ~clk;

  display_capture #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(TMO),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (i_Reset),
    .i_Segments   (i_Segments),
    .i_Digits     (i_Digits),
    .o_Data_Dig1  (o_Data_Dig1),
    .o_Data_Dig2  (o_Data_Dig2),
    .o_Data_Dig3  (o_Data_Dig3),
    .o_Data_Dig4  (o_Data_Dig4),
    .o_Blank      (o_Blank),
    .o_Dot        (o_Dot),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Error      (o_Error),
    .o_Timeout    (o_Timeout)
  );

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [3:0]      blank;
    logic            err;
    logic            tmo;
    logic            dot;
    logic [31:0]     cyc;
  } frame_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  int     t_rel = 0;
  frame_t dut_q[$];
  frame_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  logic prev_fv = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    if (o_Frame_Valid) begin
      check("fv_single_cycle", 32'(prev_fv), 32'd0);
      f.d     = {o_Data_Dig4, o_Data_Dig3, o_Data_Dig2, o_Data_Dig1};
      f.blank = o_Blank;
      f.err   = o_Error;
      f.tmo   = o_Timeout;
      f.dot   = o_Dot;
      f.cyc   = 32'(cyc);
      dut_q.push_back(f);
    end
    prev_fv = o_Frame_Valid;
  end

  // ---------------- reference model: runs of identical samples, frame = latest value per digit
  logic [7:0]      m_prev_seg;
  logic [3:0]      m_prev_dig;
  int              m_run;
  logic [3:0]      m_seen;
  logic [3:0][3:0] m_val;
  logic [3:0]      m_blank;
  logic            m_err, m_dot;

`ifdef DISPLAY_CAPTURE_DOT_EN
  localparam logic [7:0] CMP = 8'hFF;
`else
  localparam logic [7:0] CMP = 8'h7F;
`endif

  task automatic model_reset();
    m_prev_seg = '0;
    m_prev_dig = '0;
    m_run      = 0;
    m_seen     = '0;
    m_val      = '0;
    m_blank    = '0;
    m_err      = 1'b0;
    m_dot      = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_sample(input logic [7:0] seg, input logic [3:0] dig);
    bit     onehot, same;
    int     idx, v;
    frame_t f;
    onehot = ($countones(dig) == 1);
    same   = (dig == m_prev_dig) && ((seg & CMP) == (m_prev_seg & CMP));
    if (!onehot)                 m_run = 0;
    else if (same && m_run > 0)  m_run++;
    else                         m_run = 1;
    if ($countones(dig) > 1) m_err = 1'b1;
    m_prev_dig = dig;
    m_prev_seg = seg;
    if (onehot && m_run == S) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (dig[k]) idx = k;
      v = -1;
      for (int i = 0; i < 10; i++) if (SEG_LUT[i] == seg[6:0]) v = i;
      if (seg[6:0] == 7'h00) begin
        m_val[idx] = 4'h0; m_blank[idx] = 1'b1;
      end else if (v >= 0) begin
        m_val[idx] = 4'(v); m_blank[idx] = 1'b0;
      end else begin
        m_val[idx] = 4'hF; m_blank[idx] = 1'b0; m_err = 1'b1;
      end
`ifdef DISPLAY_CAPTURE_DOT_EN
      m_dot = m_dot | seg[7];
`endif
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        f       = '0;
        f.d     = m_val;
        f.blank = m_blank;
        f.err   = m_err;
        f.dot   = m_dot;
        exp_q.push_back(f);
        m_seen = '0;
        m_err  = 1'b0;
        m_dot  = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus helpers (logical active-high values, driven inverted)
  task automatic step(input logic [7:0] seg, input logic [3:0] dig);
    i_Segments = ~seg;
    i_Digits   = ~dig;
    model_sample(seg, dig);
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input int k, input logic [7:0] seg, input int n);
    repeat (n) step(seg, 4'(1 << k));
  endtask

  function automatic logic [7:0] pat(input int v);
    return {1'b0, SEG_LUT[v]};
  endfunction

  task automatic scan4(input int v1, input int v2, input int v3, input int v4);
    slot(0, pat(v1), 8);
    slot(1, pat(v2), 8);
    slot(2, pat(v3), 8);
    slot(3, pat(v4), 8);
  endtask

  task automatic do_reset();
    i_Reset    = 1'b1;
    i_Segments = 8'hFF;
    i_Digits   = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    i_Reset = 1'b0;
    model_reset();
    t_rel = cyc;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (dut_q.size() < n && i < budget) begin
      step(8'h00, 4'h0);
      i++;
    end
    check({tag, ".count"}, 32'(dut_q.size()), 32'(n));
  endtask

  function automatic frame_t mk(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                                input logic [3:0] d4, input logic [3:0] blank, input logic err,
                                input logic tmo);
    frame_t f;
    f       = '0;
    f.d     = {d4, d3, d2, d1};
    f.blank = blank;
    f.err   = err;
    f.tmo   = tmo;
    return f;
  endfunction

  task automatic cmp_frame(input string tag, input frame_t a, input frame_t e);
    check({tag, ".data"},  32'(a.d),     32'(e.d));
    check({tag, ".blank"}, 32'(a.blank), 32'(e.blank));
    check({tag, ".error"}, 32'(a.err),   32'(e.err));
    check({tag, ".tmo"},   32'(a.tmo),   32'(e.tmo));
    check({tag, ".dot"},   32'(a.dot),   32'(e.dot));
  endtask

  task automatic rand_slot(input int k);
    logic [7:0] seg, gl;
    int         r, dwell, pre, glen;
    r = $urandom_range(0, 12);
    if (r < 10)       seg = pat(r);
    else if (r == 10) seg = 8'h00;
    else if (r == 11) seg = 8'h49;
    else              seg = 8'h12;
    seg[7] = 1'($urandom_range(0, 1));
    dwell  = $urandom_range(S, 10);
    if ($urandom_range(0, 2) == 0) begin
      gl    = pat($urandom_range(0, 9));
      gl[7] = 1'($urandom_range(0, 1));
      glen  = $urandom_range(1, S - 1);
      pre   = $urandom_range(0, dwell);
      slot(k, seg, pre);
      slot(k, gl, glen);
      slot(k, seg, dwell - pre);
    end else begin
      slot(k, seg, dwell);
    end
    repeat ($urandom_range(0, 2)) step(8'h00, 4'h0);
    if ($urandom_range(0, 7) == 0) step(seg, 4'b0101);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[4];
    int tmp, j;

    // reset state
    do_reset();
    check("rst.data", 32'({o_Data_Dig4, o_Data_Dig3, o_Data_Dig2, o_Data_Dig1}), 32'd0);
    check("rst.flags", 32'({o_Blank, o_Dot, o_Frame_Valid, o_Error, o_Timeout}), 32'd0);

    // basic scan 1,2,3,4
    dut_q.delete();
    scan4(1, 2, 3, 4);
    wait_frames("basic", 1, 20);
    if (dut_q.size() >= 1) cmp_frame("basic", dut_q[0], mk(1, 2, 3, 4, 4'b0000, 0, 0));

    // Dig2 glitch 0x5B -> 0x4F for 2 cycles mid-dwell
    do_reset();
    dut_q.delete();
    slot(0, pat(1), 8);
    slot(1, 8'h5B, 4);
    slot(1, 8'h4F, 2);
    slot(1, 8'h5B, 4);
    slot(2, pat(3), 8);
    slot(3, pat(4), 8);
    wait_frames("glitch", 1, 20);
    if (dut_q.size() >= 1) cmp_frame("glitch", dut_q[0], mk(1, 2, 3, 4, 4'b0000, 0, 0));

    // digits 1-2 dark
    do_reset();
    dut_q.delete();
    slot(0, 8'h00, 8);
    slot(1, 8'h00, 8);
    slot(2, pat(0), 8);
    slot(3, pat(7), 8);
    wait_frames("dark", 1, 20);
    if (dut_q.size() >= 1) cmp_frame("dark", dut_q[0], mk(0, 0, 0, 7, 4'b0011, 0, 0));

    // only Dig1/Dig2 scanned -> timeout frame
    do_reset();
    dut_q.delete();
    repeat (269) begin
      slot(0, pat(1), 8);
      slot(1, pat(2), 8);
    end
    check("timeout.count", 32'(dut_q.size()), 32'd1);
    if (dut_q.size() >= 1) begin
      cmp_frame("timeout", dut_q[0], mk(1, 2, 0, 0, 4'b1100, 0, 1));
      check("timeout.latency_ok",
            32'((dut_q[0].cyc - 32'(t_rel) >= TMO - 6) && (dut_q[0].cyc - 32'(t_rel) <= TMO + 6)), 32'd1);
    end

    // illegal pattern on Dig3 plus a multi-hot cycle, then a clean frame
    do_reset();
    dut_q.delete();
    slot(0, pat(1), 8);
    slot(1, pat(2), 4);
    step(pat(2), 4'b0011);
    slot(1, pat(2), 4);
    slot(2, 8'h49, 8);
    slot(3, pat(4), 8);
    scan4(1, 2, 3, 4);
    wait_frames("error", 2, 20);
    if (dut_q.size() >= 1) cmp_frame("error.f0", dut_q[0], mk(1, 2, 4'hF, 4, 4'b0000, 1, 0));
    if (dut_q.size() >= 2) cmp_frame("error.f1", dut_q[1], mk(1, 2, 3, 4, 4'b0000, 0, 0));

    // reset after 3 of 4 digits accepted
    do_reset();
    dut_q.delete();
    slot(0, pat(5), 8);
    slot(1, pat(6), 8);
    slot(2, pat(7), 8);
    do_reset();
    repeat (10) step(8'h00, 4'h0);
    check("midrst.no_pulse", 32'(dut_q.size()), 32'd0);
    check("midrst.outs", 32'({o_Data_Dig4, o_Data_Dig3, o_Data_Dig2, o_Data_Dig1, o_Blank, o_Error}), 32'd0);
    scan4(5, 6, 7, 8);
    wait_frames("midrst", 1, 20);
    if (dut_q.size() >= 1) cmp_frame("midrst", dut_q[0], mk(5, 6, 7, 8, 4'b0000, 0, 0));

    // randomized scans against the reference model
    for (int t = 0; t < 40; t++) begin
      do_reset();
      dut_q.delete();
      repeat (2) begin
        for (int i = 0; i < 4; i++) order[i] = i;
        for (int i = 3; i > 0; i--) begin
          j        = $urandom_range(0, i);
          tmp      = order[i];
          order[i] = order[j];
          order[j] = tmp;
        end
        for (int i = 0; i < 4; i++) rand_slot(order[i]);
      end
      repeat (6) step(8'h00, 4'h0);
      check($sformatf("rand%0d.count", t), 32'(dut_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++)
        cmp_frame($sformatf("rand%0d.f%0d", t, i), dut_q[i], exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
